instr_stage_sequencer: RTL and testbench

Datapath-side counterpart of the control unit. It fetches each 16-bit instruction, presents its opcode, and pulses `decodeComplete`. It then samples the control flags the control unit returns, runs the ALU, memory and write-back stages in order, and pulses `writeBackComplete` to close the instruction. It sits between the instruction memory, the ALU, the data memory and the register file, and is the only generator of the two completion strobes.

---
 rtl/seq_pkg.sv | 43 ++++
 rtl/instr_stage_sequencer_if.sv | 44 ++++
 rtl/seq_watchdog.sv | 37 +++
 rtl/instr_stage_sequencer.sv | 159 +++++++++++++++
 tb/tb_instr_stage_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types for instr_stage_sequencer: FSM states, opcode map, control-flag bundle.
package seq_pkg;

    localparam int unsigned RETIRED_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_DISPATCH,
        S_EXEC,
        S_MEM,
        S_WB,
        S_DONE
    } state_e;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'd0,
        OP_STORE = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_NOT   = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_BEQ   = 4'd10,
        OP_BNE   = 4'd11,
        OP_JUMP  = 4'd12
    } opcode_e;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic write_back;
    } ctrl_flags_t;

    function automatic logic is_illegal(input logic [3:0] op);
        return op > OP_JUMP;
    endfunction

endpackage

// File: rtl/instr_stage_sequencer_if.sv
// Handshake/bus bundle between the sequencer (master) and the control unit,
// memories, ALU and register file (slave).
interface instr_stage_sequencer_if
    import seq_pkg::*;
#(
    parameter int unsigned INSTR_W = 16
);
    logic                 readInstruction;
    logic                 memRead;
    logic                 memWrite;
    logic                 writeBack;
    logic                 execute;
    logic                 jumpExecute;
    logic                 fetchReq;
    logic                 fetchValid;
    logic [INSTR_W-1:0]   instrIn;
    logic [3:0]           opcode;
    logic                 decodeComplete;
    logic                 aluStart;
    logic                 aluDone;
    logic                 aluZero;
    logic                 memStart;
    logic                 memDone;
    logic                 regWrite;
    logic                 pcLoad;
    logic                 writeBackComplete;
    logic                 illegalOp;
    logic [RETIRED_W-1:0] retired;

    modport master (
        input  readInstruction, memRead, memWrite, writeBack, execute, jumpExecute,
        input  fetchValid, instrIn, aluDone, aluZero, memDone,
        output fetchReq, opcode, decodeComplete, aluStart, memStart, regWrite,
        output pcLoad, writeBackComplete, illegalOp, retired
    );

    modport slave (
        output readInstruction, memRead, memWrite, writeBack, execute, jumpExecute,
        output fetchValid, instrIn, aluDone, aluZero, memDone,
        input  fetchReq, opcode, decodeComplete, aluStart, memStart, regWrite,
        input  pcLoad, writeBackComplete, illegalOp, retired
    );

endinterface

// File: rtl/seq_watchdog.sv
// Wait-state watchdog for instr_stage_sequencer; only built when SEQ_WATCHDOG_EN is defined.
`ifdef SEQ_WATCHDOG_EN
module seq_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic expired_o
);
    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the LIMIT-th cycle spent in one wait state.
    assign expired_o = run_i && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/instr_stage_sequencer.sv
// Datapath-side instruction sequencer: FETCH/DECODE/DISPATCH/EXEC/MEM/WB/DONE.
// Optional wait-state watchdog enabled by defining SEQ_WATCHDOG_EN.
module instr_stage_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned INSTR_W    = 16,
    parameter int unsigned WDT_CYCLES = 255
) (
    input logic                     clk,
    input logic                     reset,
    instr_stage_sequencer_if.master bus
);
    state_e               state_q, state_d;
    logic [3:0]           opcode_q, opcode_d;
    ctrl_flags_t          flags_q, flags_d;
    logic                 fetch_req_q, fetch_req_d;
    logic                 decode_cmp_q, decode_cmp_d;
    logic                 alu_start_q, alu_start_d;
    logic                 mem_start_q, mem_start_d;
    logic                 reg_write_q, reg_write_d;
    logic                 pc_load_q, pc_load_d;
    logic                 wb_cmp_q, wb_cmp_d;
    logic                 illegal_q, illegal_d;
    logic [RETIRED_W-1:0] retired_q, retired_d;
    logic                 wdt_expired;
    logic                 wdt_abort;

`ifdef SEQ_WATCHDOG_EN
    logic wdt_run;
    logic wdt_clear;

    assign wdt_run   = state_q inside {S_FETCH, S_DISPATCH, S_EXEC, S_MEM};
    assign wdt_clear = (state_d != state_q);

    seq_watchdog #(.LIMIT(WDT_CYCLES)) u_wdt (
        .clk      (clk),
        .reset    (reset),
        .run_i    (wdt_run),
        .clear_i  (wdt_clear),
        .expired_o(wdt_expired)
    );
`else
    assign wdt_expired = 1'b0 && (WDT_CYCLES != 0);
`endif

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        flags_d   = flags_q;
        pc_load_d = 1'b0;
        illegal_d = 1'b0;
        wdt_abort = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.readInstruction) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.fetchValid) begin
                    opcode_d = bus.instrIn[INSTR_W-1 -: 4];
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: state_d = S_DISPATCH;
            S_DISPATCH: begin
                if (!bus.readInstruction) begin
                    flags_d.mem_read   = bus.memRead;
                    flags_d.mem_write  = bus.memWrite;
                    flags_d.write_back = bus.writeBack;
                    if (is_illegal(opcode_q)) begin
                        illegal_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (bus.jumpExecute) begin
                        pc_load_d = 1'b1;
                        state_d   = S_DONE;
                    end else if (bus.execute) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                if (bus.aluDone) begin
                    if ((opcode_q == OP_BEQ && bus.aluZero) ||
                        (opcode_q == OP_BNE && !bus.aluZero)) begin
                        pc_load_d = 1'b1;
                    end
                    if (flags_q.mem_read || flags_q.mem_write) state_d = S_MEM;
                    else if (flags_q.write_back)               state_d = S_WB;
                    else                                       state_d = S_DONE;
                end
            end
            S_MEM: begin
                if (bus.memDone) state_d = flags_q.write_back ? S_WB : S_DONE;
            end
            S_WB:   state_d = S_DONE;
            S_DONE: state_d = bus.readInstruction ? S_FETCH : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A timeout only applies while the FSM would otherwise stay put.
        if (wdt_expired && state_d == state_q) begin
            state_d   = S_DONE;
            illegal_d = 1'b1;
            wdt_abort = 1'b1;
        end

        fetch_req_d  = (state_d == S_FETCH);
        decode_cmp_d = (state_d == S_DECODE);
        alu_start_d  = (state_d == S_EXEC) && (state_q != S_EXEC);
        mem_start_d  = (state_d == S_MEM) && (state_q != S_MEM);
        reg_write_d  = (state_d == S_WB);
        wb_cmp_d     = (state_d == S_DONE);
        retired_d    = (wb_cmp_d && !wdt_abort) ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            opcode_q     <= '0;
            flags_q      <= '0;
            fetch_req_q  <= 1'b0;
            decode_cmp_q <= 1'b0;
            alu_start_q  <= 1'b0;
            mem_start_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            pc_load_q    <= 1'b0;
            wb_cmp_q     <= 1'b0;
            illegal_q    <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            opcode_q     <= opcode_d;
            flags_q      <= flags_d;
            fetch_req_q  <= fetch_req_d;
            decode_cmp_q <= decode_cmp_d;
            alu_start_q  <= alu_start_d;
            mem_start_q  <= mem_start_d;
            reg_write_q  <= reg_write_d;
            pc_load_q    <= pc_load_d;
            wb_cmp_q     <= wb_cmp_d;
            illegal_q    <= illegal_d;
            retired_q    <= retired_d;
        end
    end

    assign bus.fetchReq          = fetch_req_q;
    assign bus.opcode            = opcode_q;
    assign bus.decodeComplete    = decode_cmp_q;
    assign bus.aluStart          = alu_start_q;
    assign bus.memStart          = mem_start_q;
    assign bus.regWrite          = reg_write_q;
    assign bus.pcLoad            = pc_load_q;
    assign bus.writeBackComplete = wb_cmp_q;
    assign bus.illegalOp         = illegal_q;
    assign bus.retired           = retired_q;

endmodule

// File: tb/tb_instr_stage_sequencer.sv
// Directed bench for instr_stage_sequencer: per-instruction expectations queued
// at drive time and checked when writeBackComplete closes the instruction.
module tb_instr_stage_sequencer;

    typedef struct {
        int lat;
        int alu;
        int mem;
        int rw;
        int pc;
        int ill;
        int op;
        int op_end;
        int retired;
        int order_ok;
        int clash;
        int done;
    } rec_t;

    localparam logic [4:0] F_MR = 5'b10000;
    localparam logic [4:0] F_MW = 5'b01000;
    localparam logic [4:0] F_WB = 5'b00100;
    localparam logic [4:0] F_EX = 5'b00010;
    localparam logic [4:0] F_JX = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    rec_t exp_q[$];

    instr_stage_sequencer_if #(.INSTR_W(16)) bus();

    instr_stage_sequencer #(.INSTR_W(16), .WDT_CYCLES(8)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.readInstruction = 1'b0;
        bus.memRead         = 1'b0;
        bus.memWrite        = 1'b0;
        bus.writeBack       = 1'b0;
        bus.execute         = 1'b0;
        bus.jumpExecute     = 1'b0;
        bus.fetchValid      = 1'b0;
        bus.instrIn         = '0;
        bus.aluDone         = 1'b0;
        bus.aluZero         = 1'b0;
        bus.memDone         = 1'b0;
    endtask

    function automatic rec_t mk(int lat, int alu, int mem, int rw, int pc, int ill, int op, int ret);
        rec_t r;
        r.lat = lat; r.alu = alu; r.mem = mem; r.rw = rw; r.pc = pc; r.ill = ill;
        r.op = op; r.op_end = op; r.retired = ret; r.order_ok = 1; r.clash = 0; r.done = 1;
        return r;
    endfunction

    task automatic check_reset(input string tag);
        chk({tag, ".strobes"}, int'({bus.fetchReq, bus.decodeComplete, bus.aluStart, bus.memStart,
                                    bus.regWrite, bus.pcLoad, bus.writeBackComplete, bus.illegalOp}), 0);
        chk({tag, ".opcode"}, int'(bus.opcode), 0);
        chk({tag, ".retired"}, int'(bus.retired), 0);
    endtask

    task automatic run_instr(input logic [15:0] instr, input logic [4:0] flg, input logic zero,
                             input int alu_wait, input int mem_wait, input bit noise,
                             input int limit, output rec_t o);
        int fcyc, wcyc, acyc, mcyc, rcyc, alu_left, mem_left;
        bit alu_pend, mem_pend, prev_dc, prev_wbc;
        o = mk(-1, 0, 0, 0, 0, 0, 0, 0);
        o.order_ok = 0; o.done = 0;
        fcyc = -1; wcyc = -1; acyc = -1; mcyc = -1; rcyc = -1;
        alu_left = 0; mem_left = 0;
        alu_pend = 1'b0; mem_pend = 1'b0; prev_dc = 1'b0; prev_wbc = 1'b0;
        @(posedge clk); #1;
        bus.readInstruction = 1'b1;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk); #1;
            o.retired = int'(bus.retired);
            o.op_end  = int'(bus.opcode);
            if (bus.fetchReq && fcyc < 0) fcyc = c;
            if (bus.decodeComplete) begin
                o.op = int'(bus.opcode);
                bus.readInstruction = 1'b0;
                {bus.memRead, bus.memWrite, bus.writeBack, bus.execute, bus.jumpExecute} = flg;
            end
            if (bus.aluStart) begin o.alu++; acyc = c; alu_pend = 1'b1; alu_left = alu_wait; end
            if (bus.memStart) begin o.mem++; mcyc = c; mem_pend = 1'b1; mem_left = mem_wait; end
            if (bus.regWrite) begin o.rw++; rcyc = c; end
            if (bus.pcLoad) o.pc++;
            if (bus.illegalOp) o.ill++;
            if ((bus.decodeComplete && bus.writeBackComplete) || (bus.decodeComplete && prev_dc) ||
                (bus.writeBackComplete && prev_wbc)) o.clash++;
            prev_dc  = bus.decodeComplete;
            prev_wbc = bus.writeBackComplete;
            if (bus.writeBackComplete) begin wcyc = c; break; end
            bus.fetchValid = bus.fetchReq || noise;
            bus.instrIn    = bus.fetchReq ? instr : ~instr;
            bus.aluZero    = zero;
            if (alu_pend) begin
                bus.aluDone = (alu_left == 0);
                if (alu_left == 0) alu_pend = 1'b0; else alu_left--;
            end else begin
                bus.aluDone = noise;
            end
            if (mem_pend) begin
                bus.memDone = (mem_left == 0);
                if (mem_left == 0) mem_pend = 1'b0; else mem_left--;
            end else begin
                bus.memDone = noise;
            end
        end
        idle_inputs();
        o.done = (wcyc >= 0) ? 1 : 0;
        o.lat  = (wcyc >= 0 && fcyc >= 0) ? wcyc - fcyc + 1 : -1;
        o.order_ok = 1;
        if (acyc >= 0 && mcyc >= 0 && mcyc <= acyc) o.order_ok = 0;
        if (mcyc >= 0 && rcyc >= 0 && rcyc <= mcyc) o.order_ok = 0;
        if (acyc >= 0 && rcyc >= 0 && rcyc <= acyc) o.order_ok = 0;
    endtask

    task automatic check_instr(input string name, input rec_t o);
        rec_t e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s.scoreboard: observed empty queue, expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        chk({name, ".done"},     o.done,     e.done);
        chk({name, ".latency"},  o.lat,      e.lat);
        chk({name, ".aluStart"}, o.alu,      e.alu);
        chk({name, ".memStart"}, o.mem,      e.mem);
        chk({name, ".regWrite"}, o.rw,       e.rw);
        chk({name, ".pcLoad"},   o.pc,       e.pc);
        chk({name, ".illegal"},  o.ill,      e.ill);
        chk({name, ".opcode"},   o.op,       e.op);
        chk({name, ".opc_hold"}, o.op_end,   e.op_end);
        chk({name, ".retired"},  o.retired,  e.retired);
        chk({name, ".order"},    o.order_ok, e.order_ok);
        chk({name, ".strobes"},  o.clash,    e.clash);
    endtask

    initial begin
        rec_t o;
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        reset = 1'b0;

        exp_q.push_back(mk(7, 1, 1, 1, 0, 0, 0, 1));
        run_instr(16'h0123, F_MR | F_WB | F_EX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("load", o);

        exp_q.push_back(mk(5, 1, 0, 0, 1, 0, 10, 2));
        run_instr(16'hA000, F_EX, 1'b1, 0, 0, 1'b0, 40, o);
        check_instr("beq_taken", o);

        exp_q.push_back(mk(5, 1, 0, 0, 0, 0, 10, 3));
        run_instr(16'hA000, F_EX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("beq_not", o);

        exp_q.push_back(mk(5, 1, 0, 0, 1, 0, 11, 4));
        run_instr(16'hB000, F_EX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("bne_taken", o);

        exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 12, 5));
        run_instr(16'hC005, F_JX | F_EX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("jump", o);

        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 15, 6));
        run_instr(16'hF000, F_JX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("illegal_f", o);

        exp_q.push_back(mk(4, 0, 0, 0, 0, 1, 13, 7));
        run_instr(16'hD000, F_EX | F_WB, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("illegal_d", o);

        exp_q.push_back(mk(6, 1, 1, 0, 0, 0, 1, 8));
        run_instr(16'h1000, F_MW | F_EX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("store", o);

        exp_q.push_back(mk(6, 1, 0, 1, 0, 0, 2, 9));
        run_instr(16'h2000, F_EX | F_WB, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("add", o);

        exp_q.push_back(mk(4, 0, 0, 0, 0, 0, 3, 10));
        run_instr(16'h3000, 5'b00000, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("no_exec", o);

        exp_q.push_back(mk(12, 1, 1, 1, 0, 0, 0, 11));
        run_instr(16'h0ABC, F_MR | F_WB | F_EX, 1'b0, 2, 3, 1'b1, 60, o);
        check_instr("load_wait_noise", o);

`ifdef SEQ_WATCHDOG_EN
        exp_q.push_back(mk(12, 1, 0, 0, 0, 1, 2, 11));
        run_instr(16'h2000, F_EX | F_WB, 1'b0, 1000, 0, 1'b0, 40, o);
        check_instr("watchdog", o);
`else
        run_instr(16'h0123, F_MR | F_WB | F_EX, 1'b0, 0, 1000, 1'b0, 30, o);
        chk("stall.done",     o.done,    0);
        chk("stall.memStart", o.mem,     1);
        chk("stall.regWrite", o.rw,      0);
        chk("stall.retired",  o.retired, 11);
`endif

        reset = 1'b1;
        @(posedge clk); #1;
        check_reset("midreset");
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("post_reset.idle", int'(bus.fetchReq), 0);

        exp_q.push_back(mk(4, 0, 0, 0, 1, 0, 12, 1));
        run_instr(16'hC000, F_JX, 1'b0, 0, 0, 1'b0, 40, o);
        check_instr("jump_after_reset", o);

        chk("scoreboard.drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
